// File: rtl/cfu_mac_sequencer.sv
// cfu_mac_sequencer: runs the CFU through a quantised dot-product tile.
// For each operand pair it issues the high then the low partial-sum op and
// accumulates both results. It then issues bias-add/quantise/clamp on the
// accumulator and returns the clamped value.
// Optional macro CFU_SEQ_TIMEOUT_EN adds a CFU watchdog with a sticky o_err.
module cfu_mac_sequencer #(
    parameter int LEN_W   = 16,
    parameter int CFU_GAP = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic [31:0]      i_cmd_bias,
    input  logic             i_cmd_relu,
    output logic             o_opd_req,
    input  logic             i_opd_valid,
    input  logic [31:0]      i_opd_a,
    input  logic [31:0]      i_opd_b,
    output logic             o_cfu_valid,
    output logic [2:0]       o_cfu_op,
    output logic [31:0]      o_cfu_rs1,
    output logic [31:0]      o_cfu_rs2,
    input  logic             i_cfu_ready,
    input  logic [31:0]      i_cfu_rd,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [31:0]      o_res_data,
    output logic             o_busy,
    output logic             o_err
);

    localparam int GAP_W = (CFU_GAP < 1) ? 1 : $clog2(CFU_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_HI, S_LO, S_FINAL, S_RESP
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       acc, opd_a, opd_b, bias, result;
    logic              relu;
    logic [LEN_W-1:0]  remaining;
    logic [GAP_W-1:0]  gap_cnt;
    logic              cfu_done, issue, abort;
    logic [2:0]        issue_op;
    logic [31:0]       issue_rs1, issue_rs2;

    assign cfu_done   = o_cfu_valid & i_cfu_ready;
    assign o_res_data = result;

`ifdef CFU_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err;

    // Watchdog: count cycles of an outstanding request, give up at TIMEOUT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (!o_cfu_valid || cfu_done || abort) wd_cnt <= '0;
            else                                   wd_cnt <= wd_cnt + 1'b1;
            if (abort)                             err <= 1'b1;
            else if (state == S_IDLE && i_cmd_valid) err <= 1'b0;
        end
    end

    assign abort = o_cfu_valid & ~i_cfu_ready & (wd_cnt == WD_W'(TIMEOUT - 1));
    assign o_err = err;
`else
    assign abort = 1'b0;
    assign o_err = 1'b0;
`endif

    // Request contents for the current CFU phase.
    always_comb begin
        issue_op  = 3'b000;
        issue_rs1 = opd_a;
        issue_rs2 = opd_b;
        case (state)
            S_LO:    issue_op = 3'b001;
            S_FINAL: begin
                issue_op  = relu ? 3'b011 : 3'b010;
                issue_rs1 = acc;
                issue_rs2 = bias;
            end
            default: ;
        endcase
    end

    // Launch when in a CFU phase, idle, and this is the last required gap
    // cycle, so the request register rises right after the gap.
    assign issue = (state == S_HI || state == S_LO || state == S_FINAL) &&
                   !o_cfu_valid && (gap_cnt <= GAP_W'(1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        o_cmd_ready = 1'b0;
        o_opd_req   = 1'b0;
        o_res_valid = 1'b0;
        o_busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) state_nxt = (i_cmd_len == '0) ? S_FINAL : S_FETCH;
            end
            S_FETCH: begin
                o_opd_req = 1'b1;
                if (i_opd_valid) state_nxt = S_HI;
            end
            S_HI:    if (cfu_done) state_nxt = S_LO;
            S_LO:    if (cfu_done) state_nxt = (remaining == LEN_W'(1)) ? S_FINAL : S_FETCH;
            S_FINAL: if (cfu_done) state_nxt = S_RESP;
            S_RESP: begin
                o_res_valid = 1'b1;
                if (i_res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Datapath: command/operand latches, accumulator, CFU request register, gap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            opd_a       <= '0;
            opd_b       <= '0;
            bias        <= '0;
            relu        <= 1'b0;
            result      <= '0;
            remaining   <= '0;
            gap_cnt     <= '0;
            o_cfu_valid <= 1'b0;
            o_cfu_op    <= '0;
            o_cfu_rs1   <= '0;
            o_cfu_rs2   <= '0;
        end else begin
            if (state == S_IDLE && i_cmd_valid) begin
                bias      <= i_cmd_bias;
                relu      <= i_cmd_relu;
                acc       <= '0;
                remaining <= i_cmd_len;
            end
            if (state == S_FETCH && i_opd_valid) begin
                opd_a <= i_opd_a;
                opd_b <= i_opd_b;
            end
            if (cfu_done) begin
                o_cfu_valid <= 1'b0;
                case (state)
                    S_HI:    acc <= acc + i_cfu_rd;
                    S_LO: begin
                        acc       <= acc + i_cfu_rd;
                        remaining <= remaining - 1'b1;
                    end
                    S_FINAL: result <= i_cfu_rd;
                    default: ;
                endcase
            end else if (abort) begin
                o_cfu_valid <= 1'b0;
            end else if (issue) begin
                o_cfu_valid <= 1'b1;
                o_cfu_op    <= issue_op;
                o_cfu_rs1   <= issue_rs1;
                o_cfu_rs2   <= issue_rs2;
            end
            if (cfu_done || abort)  gap_cnt <= GAP_W'(CFU_GAP);
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// tb_cfu_mac_sequencer: randomized bench with a responding CFU model that
// logs every completed transaction; each command's op stream, accumulated
// rs1 and returned result are derived from the tile definition.
module tb_cfu_mac_sequencer;

    localparam int LEN_W   = 4;
    localparam int CFU_GAP = 2;
    localparam int TIMEOUT = 64;

    logic             i_clk, i_rst;
    logic             i_cmd_valid, o_cmd_ready;
    logic [LEN_W-1:0] i_cmd_len;
    logic [31:0]      i_cmd_bias;
    logic             i_cmd_relu;
    logic             o_opd_req, i_opd_valid;
    logic [31:0]      i_opd_a, i_opd_b;
    logic             o_cfu_valid;
    logic [2:0]       o_cfu_op;
    logic [31:0]      o_cfu_rs1, o_cfu_rs2;
    logic             i_cfu_ready;
    logic [31:0]      i_cfu_rd;
    logic             o_res_valid, i_res_ready;
    logic [31:0]      o_res_data;
    logic             o_busy, o_err;

    cfu_mac_sequencer #(.LEN_W(LEN_W), .CFU_GAP(CFU_GAP), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_len(i_cmd_len), .i_cmd_bias(i_cmd_bias), .i_cmd_relu(i_cmd_relu),
        .o_opd_req(o_opd_req), .i_opd_valid(i_opd_valid),
        .i_opd_a(i_opd_a), .i_opd_b(i_opd_b),
        .o_cfu_valid(o_cfu_valid), .o_cfu_op(o_cfu_op),
        .o_cfu_rs1(o_cfu_rs1), .o_cfu_rs2(o_cfu_rs2),
        .i_cfu_ready(i_cfu_ready), .i_cfu_rd(i_cfu_rd),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_busy(o_busy), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs1, rs2, rd;
    } cfu_txn_t;

    cfu_txn_t    cfu_log[$];
    int          n_tests = 0, n_fail = 0;
    int          stab_err = 0, gap_err = 0, hold_err = 0;
    int          lat_min = 0, lat_max = 0;
    bit          never_ready = 0;
    logic [31:0] scr [5];
    int          scr_base = 0, scr_len = 0;
    logic [31:0] last_rs1, last_res;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CFU responder: variable latency, random or scripted results, checks
    // request stability and the idle gap between requests.
    initial begin
        cfu_txn_t cur;
        bit in_txn = 0, prev_done = 0;
        int zeros = 0, wcnt = 0, lat = 0, idx;
        i_cfu_ready = 1'b0;
        i_cfu_rd    = '0;
        cur = '{op: '0, rs1: '0, rs2: '0, rd: '0};
        forever begin
            @(negedge i_clk);
            i_cfu_ready = 1'b0;
            if (i_rst) begin
                in_txn = 0; prev_done = 0; zeros = 0;
            end else if (!o_cfu_valid) begin
                in_txn = 0;
                zeros++;
            end else begin
                if (!in_txn) begin
                    if (prev_done && zeros < CFU_GAP) gap_err++;
                    cur.op = o_cfu_op; cur.rs1 = o_cfu_rs1; cur.rs2 = o_cfu_rs2;
                    in_txn = 1; wcnt = 0;
                    lat = $urandom_range(lat_max, lat_min);
                end else if (o_cfu_op !== cur.op || o_cfu_rs1 !== cur.rs1 || o_cfu_rs2 !== cur.rs2) begin
                    stab_err++;
                end
                if (!never_ready) begin
                    if (wcnt >= lat) begin
                        idx = cfu_log.size() - scr_base;
                        cur.rd = (idx >= 0 && idx < scr_len) ? scr[idx] : $urandom;
                        i_cfu_ready = 1'b1;
                        i_cfu_rd    = cur.rd;
                        cfu_log.push_back(cur);
                        in_txn = 0; prev_done = 1; zeros = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic send_cmd(input int len, input logic [31:0] bias, input logic relu);
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (o_cmd_ready) ok = 1;
            else @(negedge i_clk);
        end
        chk("cmd_ready_seen", 32'(ok), 1);
        i_cmd_valid = 1'b1;
        i_cmd_len   = LEN_W'(len);
        i_cmd_bias  = bias;
        i_cmd_relu  = relu;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_cmd_len   = LEN_W'($urandom);
        chk("busy_after_accept", 32'(o_busy), 1);
        chk("err_after_accept", 32'(o_err), 0);
    endtask

    task automatic feed_pair(input logic [31:0] a, input logic [31:0] b, input int dly, output bit ok);
        ok = 0;
        for (int k = 0; k < 500 && !ok; k++) begin
            if (o_opd_req) ok = 1;
            else @(negedge i_clk);
        end
        chk("opd_req_seen", 32'(ok), 1);
        if (!ok) return;
        repeat (dly) begin
            @(negedge i_clk);
            if (!o_opd_req) hold_err++;
        end
        i_opd_valid = 1'b1;
        i_opd_a = a;
        i_opd_b = b;
        @(negedge i_clk);
        i_opd_valid = 1'b0;
    endtask

    // One full tile; expectations come from the tile rules applied to the
    // operands sent and the results the CFU model handed back.
    task automatic run_cmd(input int len, input logic [31:0] bias, input logic relu,
                           input int opd_dly, input int res_dly);
        logic [31:0] a[$], b[$];
        logic [31:0] sum, held;
        int base, n, s0, g0, h0, spur;
        bit ok;
        for (int i = 0; i < len; i++) begin
            a.push_back($urandom);
            b.push_back($urandom);
        end
        base = cfu_log.size();
        s0 = stab_err; g0 = gap_err; h0 = hold_err; spur = 0;
        send_cmd(len, bias, relu);
        for (int i = 0; i < len; i++) begin
            feed_pair(a[i], b[i], opd_dly, ok);
            if (!ok) return;
        end
        ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            if (o_res_valid) ok = 1;
            else begin
                if (o_opd_req) spur++;
                i_opd_valid = 1'($urandom);   // must be ignored outside FETCH
                i_opd_a = $urandom;
                @(negedge i_clk);
            end
        end
        i_opd_valid = 1'b0;
        chk("res_valid_seen", 32'(ok), 1);
        if (!ok) return;
        held = o_res_data;
        repeat (res_dly) begin
            @(negedge i_clk);
            if (o_res_data !== held || !o_res_valid || o_cmd_ready) hold_err++;
        end
        chk("cmd_ready_before_res_accept", 32'(o_cmd_ready), 0);
        i_res_ready = 1'b1;
        @(negedge i_clk);
        i_res_ready = 1'b0;
        chk("res_valid_after_accept", 32'(o_res_valid), 0);
        chk("cmd_ready_after_accept", 32'(o_cmd_ready), 1);
        chk("busy_after_accept", 32'(o_busy), 0);
        chk("spurious_opd_req", 32'(spur), 0);
        chk("hold_errors", 32'(hold_err - h0), 0);
        chk("cfu_stability", 32'(stab_err - s0), 0);
        chk("cfu_gap", 32'(gap_err - g0), 0);
        n = cfu_log.size() - base;
        chk("cfu_op_count", 32'(n), 32'(2 * len + 1));
        if (n != 2 * len + 1) return;
        sum = '0;
        for (int i = 0; i < len; i++) begin
            chk("hi_op",  32'(cfu_log[base + 2*i].op), 0);
            chk("hi_rs1", cfu_log[base + 2*i].rs1, a[i]);
            chk("hi_rs2", cfu_log[base + 2*i].rs2, b[i]);
            chk("lo_op",  32'(cfu_log[base + 2*i + 1].op), 1);
            chk("lo_rs1", cfu_log[base + 2*i + 1].rs1, a[i]);
            chk("lo_rs2", cfu_log[base + 2*i + 1].rs2, b[i]);
            sum = sum + cfu_log[base + 2*i].rd + cfu_log[base + 2*i + 1].rd;
        end
        chk("final_op",  32'(cfu_log[base + 2*len].op), relu ? 32'd3 : 32'd2);
        chk("final_rs1", cfu_log[base + 2*len].rs1, sum);
        chk("final_rs2", cfu_log[base + 2*len].rs2, bias);
        chk("result",    held, cfu_log[base + 2*len].rd);
        last_rs1 = cfu_log[base + 2*len].rs1;
        last_res = held;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit ok;
        int cnt;
        i_rst = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_len = '0; i_cmd_bias = '0; i_cmd_relu = 1'b0;
        i_opd_valid = 1'b0; i_opd_a = '0; i_opd_b = '0;
        i_res_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_cmd_ready", 32'(o_cmd_ready), 1);
        chk("rst_busy",      32'(o_busy), 0);
        chk("rst_cfu_valid", 32'(o_cfu_valid), 0);
        chk("rst_opd_req",   32'(o_opd_req), 0);
        chk("rst_res_valid", 32'(o_res_valid), 0);
        chk("rst_res_data",  o_res_data, 0);
        chk("rst_err",       32'(o_err), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // scripted tile: latency 3, results 10,-3,7,1 then 3
        lat_min = 3; lat_max = 3;
        scr[0] = 32'd10; scr[1] = -32'sd3; scr[2] = 32'd7; scr[3] = 32'd1; scr[4] = 32'd3;
        scr_base = cfu_log.size(); scr_len = 5;
        run_cmd(2, 32'd5, 1'b0, 0, 0);
        scr_len = 0;
        chk("script_rs1", last_rs1, 32'd15);
        chk("script_res", last_res, 32'd3);

        // empty tile with relu and negative bias
        run_cmd(0, -32'sd40, 1'b1, 0, 0);

        // zero-latency CFU: gap enforcement
        lat_min = 0; lat_max = 0;
        run_cmd(3, $urandom, 1'b0, 0, 0);

        // backpressure on operands and result
        lat_min = 0; lat_max = 2;
        run_cmd(2, $urandom, 1'b1, 10, 7);

        // maximum tile length for this build
        lat_min = 0; lat_max = 1;
        run_cmd((1 << LEN_W) - 1, $urandom, 1'b0, 0, 1);

        // random tiles
        for (int t = 0; t < 8; t++) begin
            lat_min = 0; lat_max = $urandom_range(4, 0);
            run_cmd($urandom_range(5, 0), $urandom, 1'($urandom),
                    $urandom_range(3, 0), $urandom_range(3, 0));
        end

        // reset while the low op is outstanding
        lat_min = 6; lat_max = 6;
        send_cmd(3, 32'd9, 1'b0);
        feed_pair($urandom, $urandom, 0, ok);
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (o_cfu_valid && o_cfu_op == 3'b001) ok = 1;
            else @(negedge i_clk);
        end
        chk("lo_reached", 32'(ok), 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst_cfu_valid", 32'(o_cfu_valid), 0);
        chk("midrst_busy",      32'(o_busy), 0);
        chk("midrst_cmd_ready", 32'(o_cmd_ready), 1);
        i_rst = 1'b0;
        @(negedge i_clk);
        lat_min = 0; lat_max = 3;
        run_cmd(2, $urandom, 1'b1, 1, 1);

`ifdef CFU_SEQ_TIMEOUT_EN
        // CFU never answers: watchdog drops the request and flags o_err
        never_ready = 1;
        send_cmd(1, 32'd1, 1'b0);
        feed_pair($urandom, $urandom, 0, ok);
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (o_cfu_valid) ok = 1;
            else @(negedge i_clk);
        end
        chk("to_valid_seen", 32'(ok), 1);
        cnt = 0;
        while (o_cfu_valid && cnt < 200) begin
            cnt++;
            @(negedge i_clk);
        end
        chk("to_valid_cycles", 32'(cnt), 32'(TIMEOUT));
        chk("to_err",       32'(o_err), 1);
        chk("to_cmd_ready", 32'(o_cmd_ready), 1);
        chk("to_res_valid", 32'(o_res_valid), 0);
        repeat (3) @(negedge i_clk);
        chk("to_err_sticky", 32'(o_err), 1);
        never_ready = 0;
        run_cmd(1, $urandom, 1'b0, 0, 0);
`else
        cnt = 0;
        chk("err_tied_low", 32'(o_err), 32'(cnt));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
